// File: rtl/sdram_read_arbiter.sv
// Arbitrates the SDRAM burst-read port between video (strict priority) and one secondary client.
// Optional watchdog abort on stalled bursts is enabled by defining SDRAM_ARB_WATCHDOG_EN.
module sdram_read_arbiter #(
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        v_rd_request,
  input  logic [22:0] v_rd_address,
  input  logic [8:0]  v_rd_burst_length,
  output logic        v_rd_available,
  output logic [31:0] v_rd_data,
  output logic        v_rd_done,
  input  logic        c_rd_request,
  input  logic [22:0] c_rd_address,
  input  logic [8:0]  c_rd_burst_length,
  output logic        c_rd_available,
  output logic [31:0] c_rd_data,
  output logic        c_rd_done,
  output logic        m_rd_request,
  output logic [22:0] m_rd_address,
  output logic [8:0]  m_rd_burst_length,
  input  logic        m_rd_available,
  input  logic [31:0] m_rd_data,
  output logic        rd_abort,
  output logic [1:0]  rd_drop
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM} state_t;

  state_t      state_q, state_d;
  logic        owner_v_q, owner_v_d;
  logic        v_pend_q, v_pend_d, c_pend_q, c_pend_d;
  logic [22:0] v_addr_q, v_addr_d, c_addr_q, c_addr_d, m_addr_q, m_addr_d;
  logic [8:0]  v_len_q, v_len_d, c_len_q, c_len_d, m_len_q, m_len_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        v_done_q, v_done_d, c_done_q, c_done_d;
  logic [1:0]  drop_q, drop_d;

  logic v_zero, c_zero, v_new, c_new, v_busy, c_busy, v_take, c_take;
  logic active, strobe, burst_end;

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int GW = $clog2(WATCHDOG_CYCLES + 1);
  logic [GW-1:0] gap_q, gap_d;
  logic          abort_q, abort_d;
`endif

  // A side is busy while it waits in its pending slot or currently owns the port.
  assign v_zero = v_rd_request && (v_rd_burst_length == 9'd0);
  assign c_zero = c_rd_request && (c_rd_burst_length == 9'd0);
  assign v_new  = v_rd_request && !v_zero;
  assign c_new  = c_rd_request && !c_zero;
  assign active = (state_q != S_IDLE);
  assign v_busy = v_pend_q || (active && owner_v_q);
  assign c_busy = c_pend_q || (active && !owner_v_q);
  assign v_take = v_new && !v_busy;
  assign c_take = c_new && !c_busy;

  assign strobe    = m_rd_available && active;
  assign burst_end = strobe && ((cnt_q + 9'd1) == m_len_q);

  always_comb begin
    state_d   = state_q;
    owner_v_d = owner_v_q;
    v_pend_d  = v_pend_q;
    v_addr_d  = v_addr_q;
    v_len_d   = v_len_q;
    c_pend_d  = c_pend_q;
    c_addr_d  = c_addr_q;
    c_len_d   = c_len_q;
    m_addr_d  = m_addr_q;
    m_len_d   = m_len_q;
    cnt_d     = cnt_q;
    v_done_d  = v_zero;
    c_done_d  = c_zero;
    drop_d    = {v_new && v_busy, c_new && c_busy};
`ifdef SDRAM_ARB_WATCHDOG_EN
    gap_d     = gap_q;
    abort_d   = 1'b0;
`endif

    if (v_take) begin
      v_pend_d = 1'b1;
      v_addr_d = v_rd_address;
      v_len_d  = v_rd_burst_length;
    end
    if (c_take) begin
      c_pend_d = 1'b1;
      c_addr_d = c_rd_address;
      c_len_d  = c_rd_burst_length;
    end
    if (strobe) cnt_d = cnt_q + 9'd1;

    unique case (state_q)
      S_IDLE: begin
        if (v_pend_q || v_take) begin
          state_d   = S_ISSUE;
          owner_v_d = 1'b1;
          v_pend_d  = 1'b0;
          m_addr_d  = v_pend_q ? v_addr_q : v_rd_address;
          m_len_d   = v_pend_q ? v_len_q : v_rd_burst_length;
          cnt_d     = 9'd0;
        end else if (c_pend_q || c_take) begin
          state_d   = S_ISSUE;
          owner_v_d = 1'b0;
          c_pend_d  = 1'b0;
          m_addr_d  = c_pend_q ? c_addr_q : c_rd_address;
          m_len_d   = c_pend_q ? c_len_q : c_rd_burst_length;
          cnt_d     = 9'd0;
        end
`ifdef SDRAM_ARB_WATCHDOG_EN
        gap_d = '0;
`endif
      end
      S_ISSUE: begin
        state_d = S_STREAM;
        if (burst_end) begin
          state_d = S_IDLE;
          if (owner_v_q) v_done_d = 1'b1;
          else           c_done_d = 1'b1;
        end
      end
      S_STREAM: begin
        if (burst_end) begin
          state_d = S_IDLE;
          if (owner_v_q) v_done_d = 1'b1;
          else           c_done_d = 1'b1;
        end
`ifdef SDRAM_ARB_WATCHDOG_EN
        else if (!strobe && (gap_q == GW'(WATCHDOG_CYCLES - 1))) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
          if (owner_v_q) v_done_d = 1'b1;
          else           c_done_d = 1'b1;
        end
        gap_d = strobe ? '0 : gap_q + 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_v_q <= 1'b0;
      v_pend_q  <= 1'b0;
      v_addr_q  <= '0;
      v_len_q   <= '0;
      c_pend_q  <= 1'b0;
      c_addr_q  <= '0;
      c_len_q   <= '0;
      m_addr_q  <= '0;
      m_len_q   <= '0;
      cnt_q     <= '0;
      v_done_q  <= 1'b0;
      c_done_q  <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_v_q <= owner_v_d;
      v_pend_q  <= v_pend_d;
      v_addr_q  <= v_addr_d;
      v_len_q   <= v_len_d;
      c_pend_q  <= c_pend_d;
      c_addr_q  <= c_addr_d;
      c_len_q   <= c_len_d;
      m_addr_q  <= m_addr_d;
      m_len_q   <= m_len_d;
      cnt_q     <= cnt_d;
      v_done_q  <= v_done_d;
      c_done_q  <= c_done_d;
      drop_q    <= drop_d;
    end
  end

`ifdef SDRAM_ARB_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      gap_q   <= gap_d;
      abort_q <= abort_d;
    end
  end
  assign rd_abort = abort_q;
`else
  // Without the watchdog the limit has no effect; the abort line stays low.
  assign rd_abort = (WATCHDOG_CYCLES < 0);
`endif

  assign m_rd_request      = (state_q == S_ISSUE);
  assign m_rd_address      = m_addr_q;
  assign m_rd_burst_length = m_len_q;
  assign v_rd_available    = strobe && owner_v_q;
  assign c_rd_available    = strobe && !owner_v_q;
  assign v_rd_data         = m_rd_data;
  assign c_rd_data         = m_rd_data;
  assign v_rd_done         = v_done_q;
  assign c_rd_done         = c_done_q;
  assign rd_drop           = drop_q;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Directed bench for sdram_read_arbiter: inputs change mid-cycle (negedge), outputs sampled 1ns later.
module tb_sdram_read_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        v_rd_request, c_rd_request, m_rd_available;
  logic [22:0] v_rd_address, c_rd_address;
  logic [8:0]  v_rd_burst_length, c_rd_burst_length;
  logic        v_rd_available, c_rd_available, v_rd_done, c_rd_done;
  logic [31:0] v_rd_data, c_rd_data, m_rd_data;
  logic        m_rd_request, rd_abort;
  logic [22:0] m_rd_address;
  logic [8:0]  m_rd_burst_length;
  logic [1:0]  rd_drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdram_read_arbiter #(.WATCHDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .v_rd_request(v_rd_request), .v_rd_address(v_rd_address),
    .v_rd_burst_length(v_rd_burst_length), .v_rd_available(v_rd_available),
    .v_rd_data(v_rd_data), .v_rd_done(v_rd_done),
    .c_rd_request(c_rd_request), .c_rd_address(c_rd_address),
    .c_rd_burst_length(c_rd_burst_length), .c_rd_available(c_rd_available),
    .c_rd_data(c_rd_data), .c_rd_done(c_rd_done),
    .m_rd_request(m_rd_request), .m_rd_address(m_rd_address),
    .m_rd_burst_length(m_rd_burst_length), .m_rd_available(m_rd_available),
    .m_rd_data(m_rd_data), .rd_abort(rd_abort), .rd_drop(rd_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    v_rd_request   = 1'b0;
    c_rd_request   = 1'b0;
    m_rd_available = 1'b0;
  endtask

  task automatic req_v(input logic [22:0] a, input logic [8:0] l);
    v_rd_request = 1'b1; v_rd_address = a; v_rd_burst_length = l;
  endtask

  task automatic req_c(input logic [22:0] a, input logic [8:0] l);
    c_rd_request = 1'b1; c_rd_address = a; c_rd_burst_length = l;
  endtask

  // n strobes to owner (vid=1 video), then the done cycle that follows the last strobe
  task automatic stream(input string tag, input int n, input bit vid);
    int fwd = 0, oth = 0, stray = 0, data_ok = 0;
    for (int i = 0; i < n; i++) begin
      next_cycle();
      m_rd_available = 1'b1;
      m_rd_data = $urandom;
      #1;
      if (vid ? v_rd_available : c_rd_available) fwd++;
      if (vid ? c_rd_available : v_rd_available) oth++;
      if (v_rd_done || c_rd_done || m_rd_request || rd_abort) stray++;
      if (v_rd_data === m_rd_data && c_rd_data === m_rd_data) data_ok++;
    end
    chk({tag, " fwd"}, fwd, n);
    chk({tag, " other"}, oth, 0);
    chk({tag, " stray"}, stray, 0);
    chk({tag, " data"}, data_ok, n);
    next_cycle(); #1;
    chk({tag, " done"}, {30'd0, v_rd_done, c_rd_done}, vid ? 2 : 1);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    v_rd_request = 0; c_rd_request = 0; m_rd_available = 0; m_rd_data = 0;
    v_rd_address = 0; c_rd_address = 0; v_rd_burst_length = 0; c_rd_burst_length = 0;
    next_cycle(); next_cycle(); #1;
    chk("rst m_req", m_rd_request, 0);
    chk("rst m_addr", m_rd_address, 0);
    chk("rst m_len", m_rd_burst_length, 0);
    chk("rst done/abort/drop", {v_rd_done, c_rd_done, rd_abort, rd_drop}, 0);
    next_cycle(); reset = 1'b0;

    // video single burst
    next_cycle(); req_v(23'h200, 9'd80); #1;
    next_cycle(); #1;
    chk("v1 m_req", m_rd_request, 1);
    chk("v1 m_addr", m_rd_address, 32'h200);
    chk("v1 m_len", m_rd_burst_length, 80);
    stream("v1", 80, 1);
    chk("v1 post m_req", m_rd_request, 0);
    chk("v1 addr hold", m_rd_address, 32'h200);

    // simultaneous requests: video wins, client follows the done cycle
    next_cycle(); req_v(23'h1000, 9'd80); req_c(23'h3000, 9'd4); #1;
    next_cycle(); #1;
    chk("sim v m_addr", {m_rd_request, 8'd0, m_rd_address}, {1'b1, 8'd0, 23'h1000});
    stream("sim v", 80, 1);
    next_cycle(); #1;
    chk("sim c m_req", m_rd_request, 1);
    chk("sim c m_addr", m_rd_address, 32'h3000);
    chk("sim c m_len", m_rd_burst_length, 4);
    stream("sim c", 4, 0);

    // drop of a second client request while pending
    next_cycle(); req_v(23'h500, 9'd3); #1;
    next_cycle(); req_c(23'h40, 9'd2); #1;
    chk("drp v issue", m_rd_address, 32'h500);
    next_cycle(); req_c(23'h80, 9'd2); #1;
    chk("drp none", rd_drop, 0);
    next_cycle(); #1;
    chk("drp pulse", rd_drop, 2'b01);
    stream("drp v", 3, 1);
    next_cycle(); #1;
    chk("drp c m_req", m_rd_request, 1);
    chk("drp c addr kept", m_rd_address, 32'h40);
    stream("drp c", 2, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1;
      if (m_rd_request || rd_drop != 0) cnt++;
    end
    chk("drp one burst", cnt, 0);

    // zero-length client request
    next_cycle(); req_c(23'h123, 9'd0); #1;
    next_cycle(); #1;
    chk("zero done", {m_rd_request, c_rd_done, rd_drop}, 4'b0100);
    next_cycle(); #1;
    chk("zero after", {m_rd_request, c_rd_done}, 0);

    // reset in the middle of a burst, then stray strobes
    next_cycle(); req_v(23'h200, 9'd80); #1;
    next_cycle(); #1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle(); m_rd_available = 1'b1; #1;
      if (v_rd_available) cnt++;
    end
    chk("rmid fwd", cnt, 10);
    next_cycle(); reset = 1'b1; #1;
    next_cycle(); reset = 1'b0; #1;
    chk("rmid m_addr", m_rd_address, 0);
    chk("rmid m_len", m_rd_burst_length, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle(); m_rd_available = 1'b1; #1;
      if (v_rd_available || c_rd_available || v_rd_done || c_rd_done || m_rd_request) cnt++;
    end
    chk("rmid stray", cnt, 0);

    // after strays in IDLE, a short burst still ends on its own length
    next_cycle(); req_c(23'h55, 9'd2); #1;
    next_cycle(); #1;
    chk("post c m_req", m_rd_request, 1);
    stream("post c", 2, 0);

`ifdef SDRAM_ARB_WATCHDOG_EN
    next_cycle(); req_v(23'h10, 9'd8); #1;
    next_cycle(); #1;
    chk("wd m_req", m_rd_request, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); m_rd_available = 1'b1; #1;
    end
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      next_cycle(); #1;
      if (rd_abort || v_rd_done) cnt++;
    end
    chk("wd early", cnt, 0);
    next_cycle(); #1;
    chk("wd abort", {rd_abort, v_rd_done}, 2'b11);
    next_cycle(); req_c(23'h77, 9'd1); #1;
    chk("wd abort end", rd_abort, 0);
    next_cycle(); #1;
    chk("wd regrant", {m_rd_request, 8'd0, m_rd_address}, {1'b1, 8'd0, 23'h77});
    stream("wd c", 1, 0);
`else
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1;
      if (rd_abort) cnt++;
    end
    chk("no wd abort", cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
